// File: rtl/relay_pkg.sv
// Shared state encoding and default word/buffer sizes for the sample buffer relay,
// its ADC reader and its serial link writer.
package relay_pkg;

    localparam int DEF_SAMPLE_W = 12;
    localparam int DEF_DEPTH    = 100;

    typedef enum logic [2:0] {
        IDLE,
        CAP_REQ,
        CAP_WAIT,
        TX_LOAD,
        TX_WAIT,
        TX_SUM,
        PASS_END
    } relay_state_e;

endpackage

// File: rtl/relay_sample_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a registered output.
module relay_sample_ram #(
    parameter int SAMPLE_W = relay_pkg::DEF_SAMPLE_W,
    parameter int DEPTH    = relay_pkg::DEF_DEPTH,
    parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] mem [DEPTH];

    // NOTE: the array itself is never reset so it can map onto RAM; only the read register clears.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sample_buffer_relay.sv
// Capture-then-forward relay: fills a buffer from the ADC reader, then replays it to the link writer.
// Optional build macro CHECKSUM_EN appends a modulo-2^SAMPLE_W sum word to every pass.
module sample_buffer_relay #(
    parameter  int SAMPLE_W = relay_pkg::DEF_SAMPLE_W,
    parameter  int DEPTH    = relay_pkg::DEF_DEPTH,
    parameter  int NUM_CH   = 1,
    parameter  int CNT_W    = $clog2(DEPTH + 1),
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                continuous,
    input  logic [CNT_W-1:0]    sample_limit,
    output logic                adc_req,
    output logic [CH_W-1:0]     adc_ch,
    input  logic                adc_done,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic                tx_req,
    output logic [SAMPLE_W-1:0] tx_data,
    input  logic                tx_done,
    output logic                busy,
    output logic                pass_done,
    output logic                overrun
);

    import relay_pkg::*;

    localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

    relay_state_e        state, state_next;
    logic [CNT_W-1:0]    lim_q, eff_lim, wr_cnt, rd_cnt;
    logic [CH_W-1:0]     ch;
    logic                cont_q;
    logic [SAMPLE_W-1:0] ram_q;
    logic                cap_hit, tx_hit, last_wr, last_rd, pass_start, tx_phase;

    assign eff_lim    = (sample_limit == '0 || sample_limit > DEPTH_C) ? DEPTH_C : sample_limit;
    assign cap_hit    = (state == CAP_WAIT) && adc_done;
    assign tx_hit     = (state == TX_WAIT) && tx_done;
    assign last_wr    = (wr_cnt + CNT_W'(1)) == lim_q;
    assign last_rd    = (rd_cnt + CNT_W'(1)) == lim_q;
    assign pass_start = start && ((state == IDLE) || (state == PASS_END && cont_q));
    assign busy       = (state != IDLE);
    assign adc_ch     = ch;

`ifdef CHECKSUM_EN
    assign tx_phase = (state == TX_WAIT) || (state == TX_SUM);
`else
    assign tx_phase = (state == TX_WAIT);
`endif

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        adc_req    = 1'b0;
        tx_req     = 1'b0;
        pass_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CAP_REQ;
            end
            CAP_REQ: begin
                adc_req    = 1'b1;
                state_next = CAP_WAIT;
            end
            CAP_WAIT: begin
                if (adc_done) state_next = last_wr ? TX_LOAD : CAP_REQ;
            end
            TX_LOAD: begin
                state_next = TX_WAIT;
            end
            TX_WAIT: begin
                tx_req = 1'b1;
`ifdef CHECKSUM_EN
                if (tx_done) state_next = last_rd ? TX_SUM : TX_LOAD;
`else
                if (tx_done) state_next = last_rd ? PASS_END : TX_LOAD;
`endif
            end
`ifdef CHECKSUM_EN
            TX_SUM: begin
                tx_req = 1'b1;
                if (tx_done) state_next = PASS_END;
            end
`endif
            PASS_END: begin
                pass_done  = 1'b1;
                state_next = (cont_q && start) ? CAP_REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Limit and mode are latched only when leaving IDLE; a continuous re-arm keeps them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lim_q  <= '0;
            cont_q <= 1'b0;
            wr_cnt <= '0;
            rd_cnt <= '0;
            ch     <= '0;
        end else begin
            if (state == IDLE && start) begin
                lim_q  <= eff_lim;
                cont_q <= continuous;
            end
            if (pass_start) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
                ch     <= '0;
            end else begin
                if (cap_hit) begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                    ch     <= (ch == LAST_CH) ? '0 : ch + CH_W'(1);
                end
                if (tx_hit) rd_cnt <= rd_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overrun <= 1'b0;
        else     overrun <= overrun | (adc_done && state != CAP_WAIT) | (tx_done && !tx_phase);
    end

    relay_sample_ram #(
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH),
        .AW       (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cap_hit),
        .wr_addr (wr_cnt[AW-1:0]),
        .wr_data (adc_data),
        .rd_en   (state == TX_LOAD),
        .rd_addr (rd_cnt[AW-1:0]),
        .rd_data (ram_q)
    );

`ifdef CHECKSUM_EN
    logic [SAMPLE_W-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             sum_q <= '0;
        else if (pass_start) sum_q <= '0;
        else if (cap_hit)    sum_q <= sum_q + adc_data;
    end

    assign tx_data = (state == TX_SUM) ? sum_q : ram_q;
`else
    assign tx_data = ram_q;
`endif

endmodule

// File: tb/tb_sample_buffer_relay.sv
// Scoreboard bench for sample_buffer_relay: captured samples are queued and matched against link words.
module tb_sample_buffer_relay;

    localparam int SAMPLE_W = 12;
    localparam int DEPTH    = 100;
    localparam int NUM_CH   = 3;
    localparam int CNT_W    = 8;
    localparam int CH_W     = 2;
`ifdef CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic                clk;
    logic                rst;
    logic                start;
    logic                continuous;
    logic [CNT_W-1:0]    sample_limit;
    logic                adc_req;
    logic [CH_W-1:0]     adc_ch;
    logic                adc_done;
    logic [SAMPLE_W-1:0] adc_data;
    logic                tx_req;
    logic [SAMPLE_W-1:0] tx_data;
    logic                tx_done;
    logic                busy;
    logic                pass_done;
    logic                overrun;

    int checks   = 0;
    int failures = 0;

    logic [SAMPLE_W-1:0] exp_q [$];
    logic [SAMPLE_W-1:0] feed_q [$];
    logic [SAMPLE_W-1:0] sum_model;
    int                  cap_idx;

    sample_buffer_relay #(
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH),
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .continuous   (continuous),
        .sample_limit (sample_limit),
        .adc_req      (adc_req),
        .adc_ch       (adc_ch),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .tx_req       (tx_req),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .busy         (busy),
        .pass_done    (pass_done),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_pass();
        exp_q.delete();
        sum_model = '0;
        cap_idx   = 0;
    endtask

    task automatic start_capture(input int lim, input bit cont);
        sample_limit = CNT_W'(lim);
        continuous   = cont;
        start        = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL start_busy got=%0b exp=1", busy);
        end
        if (!cont) start = 1'b0;
    endtask

    // Plays ADC reader and link writer until pass_done, a timeout, or the (max_tx+1)th word is requested.
    task automatic serve_pass(input int exp_cap, input int exp_tx, input int max_tx,
                              output logic [SAMPLE_W-1:0] last_word, output bit ended);
        int                  budget;
        int                  n_cap;
        int                  n_tx;
        logic [SAMPLE_W-1:0] d;
        logic [SAMPLE_W-1:0] e;
        budget    = 5000;
        n_cap     = 0;
        n_tx      = 0;
        ended     = 1'b0;
        last_word = '0;
        while (budget > 0) begin
            if (pass_done) begin
                ended = 1'b1;
                break;
            end else if (adc_req) begin
                checks++;
                if (adc_ch !== CH_W'(cap_idx % NUM_CH)) begin
                    failures++;
                    $display("FAIL adc_ch sample=%0d got=%0d exp=%0d", cap_idx, adc_ch, cap_idx % NUM_CH);
                end
                d = (feed_q.size() > 0) ? feed_q.pop_front() : SAMPLE_W'($urandom);
                tick();
                checks++;
                if (adc_req !== 1'b0) begin
                    failures++;
                    $display("FAIL adc_req_pulse got=%0b exp=0", adc_req);
                end
                adc_done = 1'b1;
                adc_data = d;
                tick();
                adc_done = 1'b0;
                exp_q.push_back(d);
                sum_model = sum_model + d;
                cap_idx++;
                n_cap++;
`ifdef CHECKSUM_EN
                if (n_cap == exp_cap) exp_q.push_back(sum_model);
`endif
            end else if (tx_req) begin
                if (n_tx == max_tx) break;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_unexpected word=%0d got=%03h exp=none", n_tx, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        failures++;
                        $display("FAIL tx_data word=%0d got=%03h exp=%03h", n_tx, tx_data, e);
                    end
                end
                last_word = tx_data;
                tx_done   = 1'b1;
                tick();
                tx_done   = 1'b0;
                n_tx++;
            end else begin
                tick();
            end
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL serve_timeout cap=%0d tx=%0d exp_cap=%0d exp_tx=%0d", n_cap, n_tx, exp_cap, exp_tx);
        end
        if (ended) begin
            checks++;
            if (n_cap !== exp_cap) begin
                failures++;
                $display("FAIL cap_count got=%0d exp=%0d", n_cap, exp_cap);
            end
            checks++;
            if (n_tx !== exp_tx) begin
                failures++;
                $display("FAIL tx_count got=%0d exp=%0d", n_tx, exp_tx);
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        start        = 1'b0;
        continuous   = 1'b0;
        sample_limit = '0;
        adc_done     = 1'b0;
        adc_data     = '0;
        tx_done      = 1'b0;
        #25;
        checks++;
        if ({adc_req, tx_req, busy, pass_done, overrun} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%05b exp=00000", {adc_req, tx_req, busy, pass_done, overrun});
        end
        checks++;
        if (tx_data !== '0 || adc_ch !== '0) begin
            failures++;
            $display("FAIL reset_data got=%03h/%0d exp=000/0", tx_data, adc_ch);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy got=%0b exp=0", busy);
        end
    endtask

    task automatic test_basic();
        logic [SAMPLE_W-1:0] lw;
        bit                  ended;
        begin_pass();
        for (int i = 1; i <= 4; i++) feed_q.push_back(SAMPLE_W'(i));
        start_capture(4, 1'b0);
        serve_pass(4, 4 + EXTRA, -1, lw, ended);
        checks++;
        if (!ended || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_pass_end got=%0b/%0b exp=1/1", ended, busy);
        end
        tick();
        checks++;
        if (pass_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_after got=%0b/%0b exp=0/0", pass_done, busy);
        end
    endtask

    task automatic test_limit_bounds();
        logic [SAMPLE_W-1:0] lw;
        bit                  ended;
        int                  lims [2] = '{0, 150};
        foreach (lims[i]) begin
            begin_pass();
            start_capture(lims[i], 1'b0);
            serve_pass(DEPTH, DEPTH + EXTRA, -1, lw, ended);
            tick();
        end
    endtask

    task automatic test_channels();
        logic [SAMPLE_W-1:0] lw;
        bit                  ended;
        begin_pass();
        start_capture(6, 1'b0);
        serve_pass(6, 6 + EXTRA, -1, lw, ended);
        tick();
    endtask

    task automatic test_continuous();
        logic [SAMPLE_W-1:0] lw;
        bit                  ended;
        int                  extra_req;
        begin_pass();
        start_capture(2, 1'b1);
        serve_pass(2, 2 + EXTRA, -1, lw, ended);
        tick();
        checks++;
        if (adc_req !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL cont_rearm got=%0b/%0b exp=1/1", adc_req, busy);
        end
        begin_pass();
        start = 1'b0;
        serve_pass(2, 2 + EXTRA, -1, lw, ended);
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL cont_stop got=%0b exp=0", busy);
        end
        extra_req = 0;
        for (int i = 0; i < 6; i++) begin
            if (adc_req) extra_req++;
            tick();
        end
        checks++;
        if (extra_req !== 0) begin
            failures++;
            $display("FAIL cont_idle_req got=%0d exp=0", extra_req);
        end
    endtask

    task automatic test_reset_mid();
        logic [SAMPLE_W-1:0] lw;
        bit                  ended;
        begin_pass();
        start_capture(6, 1'b0);
        serve_pass(6, 6 + EXTRA, 2, lw, ended);
        checks++;
        if (ended || tx_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_reach got=%0b/%0b exp=0/1", ended, tx_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tx_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=%0b/%0b exp=0/0", tx_req, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        begin_pass();
        feed_q.push_back(12'h111);
        feed_q.push_back(12'h222);
        feed_q.push_back(12'h333);
        start_capture(3, 1'b0);
        serve_pass(3, 3 + EXTRA, -1, lw, ended);
        tick();
    endtask

    task automatic test_overrun();
        logic [SAMPLE_W-1:0] lw;
        logic [SAMPLE_W-1:0] first;
        bit                  ended;
        begin_pass();
        start_capture(3, 1'b0);
        serve_pass(3, 3 + EXTRA, 0, lw, ended);
        first = exp_q[0];
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_before got=%0b exp=0", overrun);
        end
        adc_done = 1'b1;
        adc_data = 12'hABC;
        tick();
        adc_done = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_set got=%0b exp=1", overrun);
        end
        checks++;
        if (tx_req !== 1'b1 || tx_data !== first) begin
            failures++;
            $display("FAIL ovr_hold got=%0b/%03h exp=1/%03h", tx_req, tx_data, first);
        end
        serve_pass(0, 3 + EXTRA, -1, lw, ended);
        tick();
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_sticky got=%0b exp=1", overrun);
        end
    endtask

    task automatic test_checksum();
        logic [SAMPLE_W-1:0] lw;
        bit                  ended;
        begin_pass();
        feed_q.push_back(12'hFFF);
        feed_q.push_back(12'h002);
        start_capture(2, 1'b0);
        serve_pass(2, 2 + EXTRA, -1, lw, ended);
        checks++;
`ifdef CHECKSUM_EN
        if (lw !== 12'h001) begin
            failures++;
            $display("FAIL checksum_word got=%03h exp=001", lw);
        end
`else
        if (lw !== 12'h002) begin
            failures++;
            $display("FAIL last_word got=%03h exp=002", lw);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_limit_bounds();
        test_channels();
        test_continuous();
        test_reset_mid();
        test_overrun();
        test_checksum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
